axis_route_xbar: RTL and testbench

// Parametrised AXI4-Stream packet crossbar between N_SRC sources (host and DTU sinks) and N_DST destinations.

---
 rtl/axis_route_xbar.sv | 252 +++++++++++++++++++++++++
 tb/tb_axis_route_xbar.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_route_xbar.sv
// axis_route_xbar: AXI4-Stream packet crossbar from N_SRC sources to N_DST destinations.
// Each source runs a HEAD/ROUTE/DROP packet FSM; each destination has a packet-locked
// round-robin arbiter feeding a single output register stage. m_tdest carries the source index.
module axis_route_xbar #(
   parameter int N_SRC     = 6,
   parameter int N_DST     = 6,
   parameter int DATA_BITS = 512,
   parameter int ID_BITS   = 6,
   parameter int DEST_BITS = 4,
   parameter int SRC_BITS  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [N_SRC-1:0]                  s_tvalid,
   output logic [N_SRC-1:0]                  s_tready,
   input  logic [N_SRC-1:0][DATA_BITS-1:0]   s_tdata,
   input  logic [N_SRC-1:0][DATA_BITS/8-1:0] s_tkeep,
   input  logic [N_SRC-1:0]                  s_tlast,
   input  logic [N_SRC-1:0][ID_BITS-1:0]     s_tid,
   input  logic [N_SRC-1:0][DEST_BITS-1:0]   s_tdest,
   output logic [N_DST-1:0]                  m_tvalid,
   input  logic [N_DST-1:0]                  m_tready,
   output logic [N_DST-1:0][DATA_BITS-1:0]   m_tdata,
   output logic [N_DST-1:0][DATA_BITS/8-1:0] m_tkeep,
   output logic [N_DST-1:0]                  m_tlast,
   output logic [N_DST-1:0][ID_BITS-1:0]     m_tid,
   output logic [N_DST-1:0][SRC_BITS-1:0]    m_tdest,
   output logic [N_SRC-1:0]                  decode_err,
   output logic [N_SRC-1:0][15:0]            drop_cnt
);

   localparam int                   DST_BITS = (N_DST > 1) ? $clog2(N_DST) : 1;
   localparam logic [DEST_BITS:0]   N_DST_W  = (DEST_BITS+1)'(N_DST);

   typedef enum logic [1:0] {
      ST_HEAD  = 2'd0,
      ST_ROUTE = 2'd1,
      ST_DROP  = 2'd2
   } src_state_e;

   // source-side state
   src_state_e                        state_q [N_SRC];
   src_state_e                        state_d [N_SRC];
   logic [N_SRC-1:0][DST_BITS-1:0]    dest_q, dest_d;
   logic [N_SRC-1:0][15:0]            drop_cnt_q, drop_cnt_d;

   // destination-side state
   logic [N_DST-1:0]                  lock_q, lock_d;
   logic [N_DST-1:0][SRC_BITS-1:0]    rr_q, rr_d;
   logic [N_DST-1:0]                  mv_q, mv_d;
   logic [N_DST-1:0][DATA_BITS-1:0]   md_q, md_d;
   logic [N_DST-1:0][DATA_BITS/8-1:0] mk_q, mk_d;
   logic [N_DST-1:0]                  ml_q, ml_d;
   logic [N_DST-1:0][ID_BITS-1:0]     mi_q, mi_d;
   logic [N_DST-1:0][SRC_BITS-1:0]    ms_q, ms_d;

   // combinational helpers
   logic [N_SRC-1:0]                  head_ok_s;
   logic [N_SRC-1:0][DST_BITS-1:0]    tgt_s;
   logic [N_SRC-1:0][N_DST-1:0]       req_s;
   logic [N_SRC-1:0]                  win_s;
   logic [N_DST-1:0]                  space_s;
   logic [N_SRC-1:0]                  s_tready_s;
   logic [N_SRC-1:0]                  xfer_s;
   logic [N_SRC-1:0]                  fwd_s;
   logic [N_SRC-1:0]                  drop_head_s;

   // Decode each source's target destination and its head-beat request vector.
   always_comb begin
      head_ok_s = {N_SRC{1'b0}};
      tgt_s     = {(N_SRC*DST_BITS){1'b0}};
      req_s     = {(N_SRC*N_DST){1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         head_ok_s[i] = ({1'b0, s_tdest[i]} < N_DST_W);
         if (state_q[i] == ST_ROUTE) begin
            tgt_s[i] = dest_q[i];
         end else if (head_ok_s[i]) begin
            tgt_s[i] = s_tdest[i][DST_BITS-1:0];
         end else begin
            tgt_s[i] = {DST_BITS{1'b0}};
         end
         for (int d = 0; d < N_DST; d++) begin
            req_s[i][d] = (state_q[i] == ST_HEAD) && s_tvalid[i] && head_ok_s[i] &&
                          (tgt_s[i] == DST_BITS'(d));
         end
      end
   end

   // A head wins when no other source requesting the same destination precedes it in rr order;
   // its own valid is deliberately excluded so s_tready does not depend on s_tvalid.
   always_comb begin
      logic passed_v;
      int   k_v;
      passed_v = 1'b0;
      k_v      = 0;
      win_s    = {N_SRC{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         passed_v = 1'b0;
         win_s[i] = 1'b1;
         for (int o = 0; o < N_SRC; o++) begin
            k_v = (int'(rr_q[tgt_s[i]]) + o) % N_SRC;
            if (k_v == i) begin
               passed_v = 1'b1;
            end else if (!passed_v && req_s[k_v][tgt_s[i]]) begin
               win_s[i] = 1'b0;
            end else begin
               win_s[i] = win_s[i];
            end
         end
      end
   end

   // Source ready: routed beats need a grant and output space; dropped beats are always taken.
   always_comb begin
      space_s     = ~mv_q | m_tready;
      s_tready_s  = {N_SRC{1'b0}};
      drop_head_s = {N_SRC{1'b0}};
      for (int i = 0; i < N_SRC; i++) begin
         if (areset) begin
            s_tready_s[i] = 1'b0;
         end else begin
            case (state_q[i])
               ST_HEAD: begin
                  if (!head_ok_s[i]) begin
                     s_tready_s[i] = 1'b1;
                  end else begin
                     s_tready_s[i] = !lock_q[tgt_s[i]] && win_s[i] && space_s[tgt_s[i]];
                  end
               end
               ST_ROUTE: s_tready_s[i] = space_s[tgt_s[i]];
               ST_DROP:  s_tready_s[i] = 1'b1;
               default:  s_tready_s[i] = 1'b0;
            endcase
         end
         drop_head_s[i] = !areset && s_tvalid[i] && (state_q[i] == ST_HEAD) && !head_ok_s[i];
      end
      xfer_s = s_tvalid & s_tready_s;
      for (int i = 0; i < N_SRC; i++) begin
         fwd_s[i] = xfer_s[i] && ((state_q[i] == ST_ROUTE) ||
                                  ((state_q[i] == ST_HEAD) && head_ok_s[i]));
      end
   end

   // Source packet FSM next state, latched destination and saturating drop counter.
   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         state_d[i]    = state_q[i];
         dest_d[i]     = dest_q[i];
         drop_cnt_d[i] = drop_cnt_q[i];
         case (state_q[i])
            ST_HEAD: begin
               if (drop_head_s[i]) begin
                  if (drop_cnt_q[i] != 16'hFFFF) begin
                     drop_cnt_d[i] = drop_cnt_q[i] + 16'd1;
                  end else begin
                     drop_cnt_d[i] = drop_cnt_q[i];
                  end
                  state_d[i] = s_tlast[i] ? ST_HEAD : ST_DROP;
               end else if (fwd_s[i] && !s_tlast[i]) begin
                  state_d[i] = ST_ROUTE;
                  dest_d[i]  = tgt_s[i];
               end else begin
                  state_d[i] = ST_HEAD;
               end
            end
            ST_ROUTE, ST_DROP: begin
               if (xfer_s[i] && s_tlast[i]) begin
                  state_d[i] = ST_HEAD;
               end else begin
                  state_d[i] = state_q[i];
               end
            end
            default: state_d[i] = ST_HEAD;
         endcase
      end
   end

   // Destination side: load the output register, and maintain packet lock and rr pointer.
   always_comb begin
      lock_d = lock_q;
      rr_d   = rr_q;
      mv_d   = mv_q & ~m_tready;
      md_d   = md_q;
      mk_d   = mk_q;
      ml_d   = ml_q;
      mi_d   = mi_q;
      ms_d   = ms_q;
      for (int d = 0; d < N_DST; d++) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (fwd_s[i] && (tgt_s[i] == DST_BITS'(d))) begin
               mv_d[d] = 1'b1;
               md_d[d] = s_tdata[i];
               mk_d[d] = s_tkeep[i];
               ml_d[d] = s_tlast[i];
               mi_d[d] = s_tid[i];
               ms_d[d] = SRC_BITS'(i);
               if (s_tlast[i]) begin
                  lock_d[d] = 1'b0;
                  rr_d[d]   = (i == N_SRC - 1) ? {SRC_BITS{1'b0}} : SRC_BITS'(i + 1);
               end else begin
                  lock_d[d] = 1'b1;
               end
            end else begin
               mv_d[d] = mv_d[d];
            end
         end
      end
   end

   // Control state registers with synchronous reset; in-flight packets are abandoned.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < N_SRC; i++) begin
            state_q[i] <= ST_HEAD;
         end
         dest_q     <= {(N_SRC*DST_BITS){1'b0}};
         drop_cnt_q <= {(N_SRC*16){1'b0}};
         lock_q     <= {N_DST{1'b0}};
         rr_q       <= {(N_DST*SRC_BITS){1'b0}};
         mv_q       <= {N_DST{1'b0}};
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            state_q[i] <= state_d[i];
         end
         dest_q     <= dest_d;
         drop_cnt_q <= drop_cnt_d;
         lock_q     <= lock_d;
         rr_q       <= rr_d;
         mv_q       <= mv_d;
      end
   end

   // Output payload registers; contents only meaningful while m_tvalid is high.
   always_ff @(posedge aclk) begin
      md_q <= md_d;
      mk_q <= mk_d;
      ml_q <= ml_d;
      mi_q <= mi_d;
      ms_q <= ms_d;
   end

   assign s_tready   = s_tready_s;
   assign decode_err = drop_head_s;
   assign drop_cnt   = drop_cnt_q;
   assign m_tvalid   = mv_q;
   assign m_tdata    = md_q;
   assign m_tkeep    = mk_q;
   assign m_tlast    = ml_q;
   assign m_tid      = mi_q;
   assign m_tdest    = ms_q;

endmodule

// File: tb/tb_axis_route_xbar.sv
// Testbench for axis_route_xbar: directed scenarios plus randomized packet traffic,
// scored against per-(source,destination) expected beat queues built from the generated packets.
module tb_axis_route_xbar;

   localparam int NS = 6;
   localparam int ND = 6;
   localparam int DB = 32;
   localparam int KB = DB / 8;
   localparam int IB = 6;
   localparam int TB = 4;
   localparam int SB = 3;

   logic                     clk = 1'b0;
   logic                     areset;
   logic [NS-1:0]            s_tvalid, s_tready, s_tlast, decode_err;
   logic [NS-1:0][DB-1:0]    s_tdata;
   logic [NS-1:0][KB-1:0]    s_tkeep;
   logic [NS-1:0][IB-1:0]    s_tid;
   logic [NS-1:0][TB-1:0]    s_tdest;
   logic [ND-1:0]            m_tvalid, m_tready, m_tlast;
   logic [ND-1:0][DB-1:0]    m_tdata;
   logic [ND-1:0][KB-1:0]    m_tkeep;
   logic [ND-1:0][IB-1:0]    m_tid;
   logic [ND-1:0][SB-1:0]    m_tdest;
   logic [NS-1:0][15:0]      drop_cnt;

   always #5 clk = ~clk;

   axis_route_xbar #(
      .N_SRC(NS), .N_DST(ND), .DATA_BITS(DB), .ID_BITS(IB), .DEST_BITS(TB)
   ) dut (
      .aclk(clk), .areset(areset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
      .decode_err(decode_err), .drop_cnt(drop_cnt)
   );

   typedef struct packed {
      logic [DB-1:0] data;
      logic [KB-1:0] keep;
      logic          last;
      logic [IB-1:0] id;
      logic [TB-1:0] tdest;
      logic          head;
      logic          drop;
      logic [3:0]    dst;
   } beat_t;

   typedef struct packed {
      logic [DB-1:0] data;
      logic [KB-1:0] keep;
      logic          last;
      logic [IB-1:0] id;
   } out_t;

   beat_t src_q [NS][$];
   out_t  exp_q [NS*ND][$];
   int    olog  [ND][$];
   int    otime [ND][$];
   bit    pres  [NS];
   int    acc_cnt [NS];
   int    obs_derr [NS];
   int    gen_drop [NS];
   int    own [ND];
   bit    stall [ND];
   logic [63:0] saved [ND];
   int    rdy_mode [ND];
   int    gap_pct;
   int    cyc;
   int    n_chk;
   int    n_fail;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic add_pkt(input int src, input int dst, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data  = $urandom;
         b.keep  = KB'($urandom);
         b.last  = (k == len - 1);
         b.id    = IB'($urandom);
         b.tdest = (k == 0) ? TB'(dst) : TB'($urandom_range(15, 0));
         b.head  = (k == 0);
         b.drop  = (dst >= ND);
         b.dst   = 4'(dst);
         src_q[src].push_back(b);
      end
   endtask

   task automatic clear_logs();
      for (int d = 0; d < ND; d++) begin
         olog[d].delete();
         otime[d].delete();
      end
      for (int i = 0; i < NS; i++) begin
         acc_cnt[i]  = 0;
         obs_derr[i] = 0;
      end
   endtask

   function automatic int busy();
      int b;
      b = 0;
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) b = 1;
      for (int j = 0; j < NS*ND; j++) if (exp_q[j].size() != 0) b = 1;
      if (m_tvalid != '0) b = 1;
      return b;
   endfunction

   // Sample at the falling edge: decode_err, source handshakes and destination outputs.
   task automatic monitor();
      logic [NS-1:0] exp_de;
      beat_t b;
      out_t  cur, e;
      int    s;
      exp_de = '0;
      for (int i = 0; i < NS; i++)
         if (pres[i] && src_q[i][0].head && src_q[i][0].drop) exp_de[i] = 1'b1;
      check_val("decode_err", decode_err, exp_de);
      for (int i = 0; i < NS; i++) begin
         if (decode_err[i]) obs_derr[i]++;
         if (pres[i] && s_tready[i]) begin
            b = src_q[i].pop_front();
            pres[i] = 1'b0;
            acc_cnt[i]++;
            if (!b.drop) exp_q[i*ND + int'(b.dst)].push_back({b.data, b.keep, b.last, b.id});
         end
      end
      for (int d = 0; d < ND; d++) begin
         if (m_tvalid[d]) begin
            cur = {m_tdata[d], m_tkeep[d], m_tlast[d], m_tid[d]};
            if (stall[d]) check_val("hold", {18'd0, cur, m_tdest[d]}, saved[d]);
            if (m_tready[d]) begin
               s = int'(m_tdest[d]);
               stall[d] = 1'b0;
               if (s >= NS) begin
                  check_val("src_range", 64'(s), 64'(NS - 1));
               end else begin
                  if (own[d] >= 0) check_val("atomic", 64'(s), 64'(own[d]));
                  if (exp_q[s*ND + d].size() == 0) begin
                     check_val("unexpected_beat", 64'(d), 64'(99));
                  end else begin
                     e = exp_q[s*ND + d].pop_front();
                     check_val("beat", 64'(cur), 64'(e));
                  end
               end
               own[d] = m_tlast[d] ? -1 : s;
               olog[d].push_back(s);
               otime[d].push_back(cyc);
            end else begin
               stall[d] = 1'b1;
               saved[d] = {18'd0, cur, m_tdest[d]};
            end
         end else begin
            stall[d] = 1'b0;
         end
      end
   endtask

   // One clock: drive just after the rising edge, then check at the falling edge.
   task automatic tick();
      beat_t b;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++) begin
         if (!pres[i] && src_q[i].size() != 0 && $urandom_range(99, 0) >= gap_pct) pres[i] = 1'b1;
         if (pres[i]) begin
            b = src_q[i][0];
            s_tvalid[i] = 1'b1;
            s_tdata[i]  = b.data;
            s_tkeep[i]  = b.keep;
            s_tlast[i]  = b.last;
            s_tid[i]    = b.id;
            s_tdest[i]  = b.tdest;
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'($urandom);
            s_tdest[i]  = TB'($urandom);
         end
      end
      for (int d = 0; d < ND; d++)
         m_tready[d] = (rdy_mode[d] == 0) ? 1'b1 : (rdy_mode[d] == 1) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      monitor();
   endtask

   task automatic do_reset();
      int sum;
      areset = 1'b1;
      for (int i = 0; i < NS; i++) begin
         src_q[i].delete();
         pres[i] = 1'b0;
      end
      s_tvalid = '0;
      s_tdest  = {NS{4'hF}};
      @(posedge clk);
      @(negedge clk);
      sum = 0;
      for (int i = 0; i < NS; i++) sum += int'(drop_cnt[i]);
      check_val("rst_m_tvalid", m_tvalid, 0);
      check_val("rst_s_tready", s_tready, 0);
      check_val("rst_drop_cnt", 64'(sum), 0);
      areset = 1'b0;
      for (int j = 0; j < NS*ND; j++) exp_q[j].delete();
      for (int d = 0; d < ND; d++) begin
         own[d]   = -1;
         stall[d] = 1'b0;
      end
      clear_logs();
   endtask

   task automatic run_until_idle(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (busy() != 0 && n < max_cyc) begin
         tick();
         n++;
      end
      check_val({tag, "_idle"}, 64'(busy()), 0);
   endtask

   task automatic wait_acc(input string tag, input int src, input int n);
      int k;
      k = 0;
      while (acc_cnt[src] < n && k < 50) begin
         tick();
         k++;
      end
      check_val(tag, 64'(acc_cnt[src] >= n), 1);
   endtask

   initial begin
      int exp2 [6];
      int t5d [3];
      int st, a0, dst, len, tot;
      exp2 = '{0, 0, 0, 3, 3, 3};
      t5d  = '{0, 1, 5};
      n_chk = 0; n_fail = 0; cyc = 0; gap_pct = 0;
      areset = 1'b0;
      s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tid = '0; s_tdest = '0;
      m_tready = '1;
      for (int d = 0; d < ND; d++) rdy_mode[d] = 0;
      do_reset();

      // reset in the middle of a packet, then a fresh packet routes normally
      add_pkt(0, 2, 4);
      wait_acc("t1_start", 0, 2);
      do_reset();
      add_pkt(0, 2, 4);
      run_until_idle("t1", 50);
      check_val("t1_beats", 64'(olog[2].size()), 4);

      // contention on dst1 from src0 and src3, rr pointer at 0
      clear_logs();
      add_pkt(0, 1, 3);
      add_pkt(3, 1, 3);
      run_until_idle("t2", 50);
      check_val("t2_count", 64'(olog[1].size()), 6);
      for (int k = 0; k < olog[1].size() && k < 6; k++) check_val("t2_order", 64'(olog[1][k]), 64'(exp2[k]));
      if (otime[1].size() == 6) check_val("t2_b2b", 64'(otime[1][5] - otime[1][0]), 5);

      // invalid destination on src2
      clear_logs();
      add_pkt(2, 9, 5);
      run_until_idle("t3", 50);
      tot = 0;
      for (int d = 0; d < ND; d++) tot += olog[d].size();
      check_val("t3_accepted", 64'(acc_cnt[2]), 5);
      check_val("t3_no_output", 64'(tot), 0);
      check_val("t3_derr", 64'(obs_derr[2]), 1);
      check_val("t3_drop_cnt", 64'(drop_cnt[2]), 1);

      // backpressure on dst4 during src1 packet
      clear_logs();
      add_pkt(1, 4, 6);
      wait_acc("t4_start", 1, 2);
      rdy_mode[4] = 2;
      a0 = acc_cnt[1];
      repeat (10) tick();
      check_val("t4_stalled_acc", 64'(acc_cnt[1] - a0), 0);
      check_val("t4_s_tready", 64'(s_tready[1]), 0);
      check_val("t4_m_tvalid", 64'(m_tvalid[4]), 1);
      rdy_mode[4] = 0;
      run_until_idle("t4", 50);
      check_val("t4_beats", 64'(olog[4].size()), 6);

      // three independent packets in parallel
      clear_logs();
      add_pkt(0, 0, 8);
      add_pkt(1, 1, 8);
      add_pkt(5, 5, 8);
      st = cyc + 1;
      run_until_idle("t5", 50);
      for (int j = 0; j < 3; j++) begin
         check_val("t5_count", 64'(olog[t5d[j]].size()), 8);
         if (otime[t5d[j]].size() == 8) begin
            check_val("t5_latency", 64'(otime[t5d[j]][0] - st), 1);
            check_val("t5_finish", 64'(otime[t5d[j]][7] - st), 8);
         end
      end

      // randomized traffic with gaps and random output backpressure
      do_reset();
      gap_pct = 25;
      for (int d = 0; d < ND; d++) rdy_mode[d] = 1;
      for (int i = 0; i < NS; i++) begin
         gen_drop[i] = 0;
         repeat (25) begin
            dst = $urandom_range(9, 0);
            len = $urandom_range(5, 1);
            add_pkt(i, dst, len);
            if (dst >= ND) gen_drop[i]++;
         end
      end
      run_until_idle("rand", 20000);
      for (int i = 0; i < NS; i++) begin
         check_val("rand_drop_cnt", 64'(drop_cnt[i]), 64'(gen_drop[i]));
         check_val("rand_derr", 64'(obs_derr[i]), 64'(gen_drop[i]));
      end
      gap_pct = 0;
      for (int d = 0; d < ND; d++) rdy_mode[d] = 0;

      // drop counter saturation on src4
      do_reset();
      for (int k = 0; k < 65540; k++) add_pkt(4, 12, 1);
      run_until_idle("t6", 70000);
      check_val("t6_drop_sat", 64'(drop_cnt[4]), 64'hFFFF);
      check_val("t6_derr", 64'(obs_derr[4]), 65540);
      do_reset();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
